inst_fetch: RTL

- Consumer end of the PC stream for the RV32I core. Takes P_PC/P_VALID from the program counter and returns STALL to it.
- Issues in-order instruction reads to instruction memory and buffers {pc, inst} pairs in a DEPTH-entry queue for decode.
- Sits between the program counter and the decode stage; on FLUSH it discards queued and in-flight fetches.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 118 +++++++++++
 rtl/inst_fetch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared constants and types for the RV32I core front end.
// Contents : RESET_VECTOR - first fetch address after reset
//            NOP_INST     - canonical NOP (addi x0, x0, 0)
//            fetch_entry_t - one fetch-queue slot {pc, inst, filled}
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h2000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Circular buffer of {pc, inst, filled} entries for the fetch
//            stage. Entries are allocated when a read is issued, filled in
//            order when read data returns, and popped from the head.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            flush           - discard every entry and reset all pointers
//            alloc_en/pc     - allocate tail entry for a new request
//            fill_en/inst    - write returned data into oldest unfilled entry
//            pop_en          - decode accepts head (honoured only if filled)
//            pending         - allocated entries still awaiting data
//            full            - all DEPTH entries allocated
//            head_valid/pc/inst - registered head entry contents
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          alloc_en,
  input  logic [31:0]   alloc_pc,
  input  logic          fill_en,
  input  logic [31:0]   fill_inst,
  input  logic          pop_en,
  output logic [CW-1:0] pending,
  output logic          full,
  output logic          head_valid,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_inst
);

  localparam int PW = CW - 1;

  fetch_entry_t   entry_q [DEPTH];
  fetch_entry_t   entry_d [DEPTH];
  logic [PW-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]  fill_ptr_q,  fill_ptr_d;
  logic [PW-1:0]  head_ptr_q,  head_ptr_d;
  logic [CW-1:0]  count_q,     count_d;
  logic [CW-1:0]  pend_q,      pend_d;
  logic           do_alloc, do_fill, do_pop;

  assign full       = (count_q == CW'(DEPTH));
  assign pending    = pend_q;
  assign head_valid = entry_q[head_ptr_q].filled;
  assign head_pc    = entry_q[head_ptr_q].pc;
  assign head_inst  = entry_q[head_ptr_q].inst;

  // The three slots touched in one cycle never collide: alloc needs a free
  // slot, fill needs an unfilled allocated slot, pop needs a filled slot.
  assign do_alloc = alloc_en && !full && !flush;
  assign do_fill  = fill_en && (pend_q != '0) && !flush;
  assign do_pop   = pop_en && head_valid && !flush;

  always_comb begin
    entry_d     = entry_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    pend_d      = pend_q;
    if (flush) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      pend_d      = '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_d[i].filled = 1'b0;
      end
    end else begin
      if (do_alloc) begin
        entry_d[alloc_ptr_q].pc     = alloc_pc;
        entry_d[alloc_ptr_q].filled = 1'b0;
        alloc_ptr_d                 = alloc_ptr_q + PW'(1);
      end
      if (do_fill) begin
        entry_d[fill_ptr_q].inst   = fill_inst;
        entry_d[fill_ptr_q].filled = 1'b1;
        fill_ptr_d                 = fill_ptr_q + PW'(1);
      end
      if (do_pop) begin
        entry_d[head_ptr_q].filled = 1'b0;
        head_ptr_d                 = head_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_alloc) - CW'(do_pop);
      pend_d  = pend_q + CW'(do_alloc) - CW'(do_fill);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      pend_q      <= '0;
    end else begin
      entry_q     <= entry_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction fetch stage. Accepts PCs from the program counter,
//            issues in-order reads to instruction memory, and presents
//            {pc, inst} pairs to decode through a DEPTH-entry queue. FLUSH
//            discards queued entries; responses to reads already in flight
//            are dropped via drop_cnt.
// Ports    : CLK, RST_N          - clock, asynchronous active-low reset
//            P_PC, P_VALID, STALL - program-counter handshake
//            FLUSH               - redirect, drop queued and in-flight fetches
//            MEM_RDEN/RADDR/BUSY - instruction memory request
//            MEM_RVALID/RDATA    - in-order memory response
//            F_VALID/PC/INST/READY - decode handshake
// Option   : INST_FETCH_PERF_EN adds PERF_STALL_CYC, PERF_BUBBLE_CYC and
//            PERF_FLUSH_CNT counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] P_PC,
  input  logic        P_VALID,
  input  logic        FLUSH,
  output logic        STALL,
  output logic        MEM_RDEN,
  output logic [31:0] MEM_RADDR,
  input  logic        MEM_BUSY,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic        F_VALID,
  output logic [31:0] F_PC,
  output logic [31:0] F_INST,
  input  logic        F_READY
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0] PERF_STALL_CYC,
  output logic [31:0] PERF_BUBBLE_CYC,
  output logic [15:0] PERF_FLUSH_CNT
`endif
);

  logic          full;
  logic [CW-1:0] pending;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          take;
  logic          rsp_drop;
  logic          fill_en;

  // RST_N is folded in so the memory request drops the instant reset asserts.
  always_comb begin
    take = RST_N && P_VALID && !FLUSH && !MEM_BUSY && !full &&
           (drop_cnt_q < CW'(DEPTH));
  end

  assign MEM_RDEN  = take;
  assign MEM_RADDR = {P_PC[31:2], 2'b00};

  always_comb begin
    STALL = 1'b1;
    if (RST_N) begin
      if (P_VALID) begin
        STALL = !take;
      end else begin
        STALL = MEM_BUSY || full;
      end
    end
  end

  assign rsp_drop = MEM_RVALID && (drop_cnt_q != '0);
  assign fill_en  = MEM_RVALID && (drop_cnt_q == '0);

  // On flush every outstanding read becomes a drop. A response landing in the
  // flush cycle itself is consumed here (whether it would have been dropped
  // or filled), so it is not counted again.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (FLUSH) begin
      drop_cnt_d = drop_cnt_q + pending;
      if (MEM_RVALID && ((drop_cnt_q != '0) || (pending != '0))) begin
        drop_cnt_d = drop_cnt_d - CW'(1);
      end
    end else if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk        (CLK),
    .rst_n      (RST_N),
    .flush      (FLUSH),
    .alloc_en   (take),
    .alloc_pc   (P_PC),
    .fill_en    (fill_en),
    .fill_inst  (MEM_RDATA),
    .pop_en     (F_READY),
    .pending    (pending),
    .full       (full),
    .head_valid (F_VALID),
    .head_pc    (F_PC),
    .head_inst  (F_INST)
  );

`ifdef INST_FETCH_PERF_EN
  logic [31:0] perf_stall_q,  perf_stall_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;
  logic [15:0] perf_flush_q,  perf_flush_d;

  always_comb begin
    perf_stall_d  = perf_stall_q  + 32'(P_VALID && STALL);
    perf_bubble_d = perf_bubble_q + 32'(F_READY && !F_VALID);
    perf_flush_d  = perf_flush_q  + 16'(FLUSH);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_stall_q  <= '0;
      perf_bubble_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_bubble_q <= perf_bubble_d;
      perf_flush_q  <= perf_flush_d;
    end
  end

  assign PERF_STALL_CYC  = perf_stall_q;
  assign PERF_BUBBLE_CYC = perf_bubble_q;
  assign PERF_FLUSH_CNT  = perf_flush_q;
`endif

endmodule
`default_nettype wire
